// File: rtl/tdm_demux8.sv
// -----------------------------------------------------------------------------
// tdm_demux8 -- time-division demultiplexer, serial word stream -> 8 lanes.
//
// Words arrive one per accepted cycle and are written to capture lane `slot`.
// The word written to lane 7 completes a frame: all eight lanes move to the
// single-entry output register on that edge. A start-of-frame word always
// lands in lane 0 and discards any partial frame.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   in_data    in   W-bit input word
//   in_valid   in   in_data valid this cycle
//   in_ready   out  word can be accepted this cycle
//   in_sof     in   start of frame (qualified by accept)
//   in_par     in   even parity of in_data      (TDM_DEMUX8_PARITY_EN only)
//   out_perr   out  parity error seen in frame  (TDM_DEMUX8_PARITY_EN only)
//   out_lanes  out  completed frame, lane k at [k*W +: W]
//   out_valid  out  out_lanes holds an unconsumed frame
//   out_ready  in   consumer takes the frame when high with out_valid
//   slot       out  index of the next lane to be written
//
// Optional feature macro: TDM_DEMUX8_PARITY_EN
// -----------------------------------------------------------------------------
module tdm_demux8 #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   in_data,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_sof,
`ifdef TDM_DEMUX8_PARITY_EN
    input  logic           in_par,
    output logic           out_perr,
`endif
    output logic [8*W-1:0] out_lanes,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2:0]     slot
);

`ifdef TDM_DEMUX8_PARITY_EN
    // Even parity bit of a word: the bit that makes the total count of ones even.
    function automatic logic even_par(input logic [W-1:0] d);
        even_par = ^d;
    endfunction
`endif

    // Lane 7 never needs storage: its word goes straight to the output register.
    logic [6:0][W-1:0] cap_q, cap_d;
    logic [2:0]        slot_q, slot_d;
    logic [8*W-1:0]    out_lanes_q, out_lanes_d;
    logic              out_valid_q, out_valid_d;
    logic              accept_s;
    logic              complete_s;
    logic              consume_s;
    logic              in_ready_s;
`ifdef TDM_DEMUX8_PARITY_EN
    logic              perr_q, perr_d;
    logic              out_perr_q, out_perr_d;
    logic              mismatch_s;
`endif

    // Next-state logic: capture, frame completion, output handshake.
    always_comb begin
        // A completing word is held off only while the output is full and not draining.
        in_ready_s  = ~((slot_q == 3'd7) & out_valid_q & ~out_ready);
        accept_s    = in_valid & in_ready_s;
        complete_s  = accept_s & ~in_sof & (slot_q == 3'd7);
        consume_s   = out_valid_q & out_ready;
        cap_d       = cap_q;
        slot_d      = slot_q;
        out_lanes_d = out_lanes_q;
        out_valid_d = out_valid_q;

        if (accept_s) begin
            if (in_sof) begin
                cap_d[0] = in_data;
                slot_d   = 3'd1;
            end else if (slot_q != 3'd7) begin
                cap_d[slot_q] = in_data;
                slot_d        = slot_q + 3'd1;
            end else begin
                slot_d = 3'd0;
            end
        end else begin
            slot_d = slot_q;
        end

        // A new frame wins over a simultaneous consume, keeping out_valid high.
        if (complete_s) begin
            out_lanes_d = {in_data, cap_q};
            out_valid_d = 1'b1;
        end else if (consume_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

`ifdef TDM_DEMUX8_PARITY_EN
        mismatch_s = accept_s & (in_par != even_par(in_data));
        perr_d     = perr_q;
        out_perr_d = out_perr_q;
        if (accept_s & in_sof) begin
            perr_d = mismatch_s;
        end else if (complete_s) begin
            out_perr_d = perr_q | mismatch_s;
            perr_d     = 1'b0;
        end else begin
            perr_d = perr_q | mismatch_s;
        end
`endif
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_q       <= '0;
            slot_q      <= 3'd0;
            out_lanes_q <= '0;
            out_valid_q <= 1'b0;
`ifdef TDM_DEMUX8_PARITY_EN
            perr_q      <= 1'b0;
            out_perr_q  <= 1'b0;
`endif
        end else begin
            cap_q       <= cap_d;
            slot_q      <= slot_d;
            out_lanes_q <= out_lanes_d;
            out_valid_q <= out_valid_d;
`ifdef TDM_DEMUX8_PARITY_EN
            perr_q      <= perr_d;
            out_perr_q  <= out_perr_d;
`endif
        end
    end

    assign in_ready  = in_ready_s;
    assign out_lanes = out_lanes_q;
    assign out_valid = out_valid_q;
    assign slot      = slot_q;
`ifdef TDM_DEMUX8_PARITY_EN
    assign out_perr  = out_perr_q;
`endif

endmodule

// File: doc/tdm_demux8.md
TDM_DEMUX8 -- requirements
Module: tdm_demux8

Interface
REQ-001 Parameter W, default 8: width of one data word (one lane).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_data  input  W  serial word stream, one word per accepted cycle.
REQ-005 in_valid  input  1  in_data valid this cycle.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 in_sof  input  1  start-of-frame, qualified by in_valid; marks the word as slot 0.
REQ-008 out_lanes  output  8*W  completed frame, lane k at bits [k*W +: W].
REQ-009 out_valid  output  1  out_lanes holds an unconsumed frame.
REQ-010 out_ready  input  1  consumer accepts the frame when high with out_valid.
REQ-011 slot  output  3  index of the next slot to be written.

Function
REQ-012 Accept = in_valid & in_ready; only accepted words change state.
REQ-013 Accepted word is written to capture lane `slot`; slot then increments, wrapping 7->0.
REQ-014 Accepted word with in_sof=1 is written to lane 0 regardless of slot; any partial frame is discarded; slot becomes 1.
REQ-015 Frame completes on the accepted word written to lane 7; the 8 capture lanes transfer to out_lanes on the same edge, and out_valid is set.
REQ-016 Output register is single-entry; out_valid clears on an edge where out_valid & out_ready, unless a new frame completes on that same edge, in which case out_valid stays 1 with the new lanes.
REQ-017 in_ready = 1 except when slot==7 and out_valid=1 and out_ready=0, i.e. a completing word is never accepted while the output is full and unconsumed.
REQ-018 Latency: lane-7 word accepted at edge N -> out_valid=1 and full frame visible after edge N.
REQ-019 out_lanes is stable while out_valid=1 and out_ready=0.
REQ-020 in_valid=0 cycles hold all state; no timeout.
REQ-021 in_sof with in_valid=0, or in_sof on a non-accepted cycle, has no effect.
REQ-022 in_sof on the word that would be slot 7 still restarts at lane 0; no frame completes.

Reset
REQ-023 On an edge with rst_n=0: slot=0, out_valid=0, out_lanes=0, capture lanes=0, any partial frame is discarded; in_ready=1 from the first cycle after reset.
REQ-024 Reset overrides every simultaneous accept or consume on the same edge.

Configuration
REQ-025 Macro TDM_DEMUX8_PARITY_EN: when defined, adds input in_par (1, even parity of in_data) and output out_perr (1).
REQ-026 With the macro: a sticky error flag sets on any accepted word whose parity mismatches; it transfers to out_perr with the frame and then clears; in_sof and reset also clear it (reset value out_perr=0).
REQ-027 Without the macro: in_par and out_perr do not exist and behaviour is otherwise identical.

Verification
REQ-028 Reset, then in_sof with words 0x10..0x17, out_ready=1 -> out_valid=1 one edge after 0x17, out_lanes lane k = 0x10+k, then out_valid=0.
REQ-029 Two frames back-to-back with out_ready=0 -> in_ready=0 at slot 7 of frame 2; frame 1 held unchanged; raising out_ready accepts frame 2's last word on the consume edge and out_valid stays 1 with frame 2.
REQ-030 5 words, then in_sof plus 8 words 0xA0..0xA7 -> single frame output 0xA0..0xA7; the partial frame never appears.
REQ-031 rst_n=0 for one edge mid-frame (slot=4) with out_valid=1 -> slot=0, out_valid=0, out_lanes=0, in_ready=1.
REQ-032 Random in_valid gaps (50%) over 100 frames -> every frame in order, no loss or duplication; slot wraps 7->0 without in_sof.
REQ-033 With TDM_DEMUX8_PARITY_EN: bad parity on slot 3 -> out_perr=1 with that frame and 0 on the next clean frame.
